// File: rtl/or_reduce_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : or_reduce_pkg
//  Description : Tree-depth and stage-partitioning helpers for or_reduce_pipe.
//  Revision    : 1.0 - initial release
// ============================================================================
package or_reduce_pkg;

    localparam int c_def_width            = 32;
    localparam int c_def_levels_per_stage = 2;
    localparam int c_def_cnt_w            = 8;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r++;
        return r;
    endfunction

    function automatic int tree_depth(input int width);
        return clog2(width);
    endfunction

    function automatic int num_stages(input int width, input int lps);
        int s;
        s = (tree_depth(width) + lps - 1) / lps;
        return (s < 1) ? 1 : s;
    endfunction

    // Tree level reached at stage boundary b; boundary 0 is the padded input word.
    function automatic int bound_level(input int width, input int lps, input int b);
        int lv;
        lv = b * lps;
        if (lv > tree_depth(width)) lv = tree_depth(width);
        return lv;
    endfunction

    function automatic int bound_width(input int width, input int lps, input int b);
        return 1 << (tree_depth(width) - bound_level(width, lps, b));
    endfunction

    function automatic int bound_offset(input int width, input int lps, input int b);
        int off;
        off = 0;
        for (int j = 0; j < b; j++) off += bound_width(width, lps, j);
        return off;
    endfunction

endpackage
`default_nettype wire

// File: rtl/or_reduce_pipe_stage.sv
`default_nettype none
// ============================================================================
//  Module      : or_tree_stage
//  Description : LEVELS levels of 2-input OR, optionally followed by an
//                enable-gated register carrying valid/last.
//  Revision    : 1.0 - initial release
// ============================================================================
module or_tree_stage
    import or_reduce_pkg::*;
#(
    parameter int IN_W   = 2,
    parameter int LEVELS = 1,
    parameter int REG_EN = 1,
    parameter int OUT_W  = IN_W >> LEVELS
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             en,
    input  logic             in_valid,
    input  logic             in_last,
    input  logic [IN_W-1:0]  in_data,
    output logic             out_valid,
    output logic             out_last,
    output logic [OUT_W-1:0] out_data
);

    localparam int c_group = 1 << LEVELS;

    logic [OUT_W-1:0] w_red;

    // A reduction over 2^LEVELS bits is exactly LEVELS balanced OR levels.
    for (genvar i = 0; i < OUT_W; i++) begin : g_or
        assign w_red[i] = |in_data[i*c_group +: c_group];
    end

    if (REG_EN != 0) begin : g_reg
        logic             r_valid;
        logic             r_last;
        logic [OUT_W-1:0] r_data;

        always_ff @(posedge clock or posedge reset) begin
            if (reset) begin
                r_valid <= 1'b0;
                r_last  <= 1'b0;
                r_data  <= '0;
            end else if (en) begin
                r_valid <= in_valid;
                r_last  <= in_last;
                r_data  <= w_red;
            end
        end

        assign out_valid = r_valid;
        assign out_last  = r_last;
        assign out_data  = r_data;
    end else begin : g_comb
        // The final stage feeds the output register in the parent directly.
        logic w_unused;
        assign w_unused  = ^{clock, reset, en};
        assign out_valid = in_valid;
        assign out_last  = in_last;
        assign out_data  = w_red;
    end

endmodule
`default_nettype wire

// File: rtl/or_reduce_pipe.sv
`default_nettype none
// ============================================================================
//  Module      : or_reduce_pipe
//  Description : Pipelined WIDTH-bit OR reduction with valid/ready handshake.
//                Define OR_REDUCE_ACCUM_EN to OR whole frames and count beats.
//  Revision    : 1.0 - initial release
// ============================================================================
module or_reduce_pipe
    import or_reduce_pkg::*;
#(
    parameter int WIDTH            = c_def_width,
    parameter int LEVELS_PER_STAGE = c_def_levels_per_stage,
    parameter int CNT_W            = c_def_cnt_w
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_any,
    output logic             out_none,
    output logic [CNT_W-1:0] out_beats
);

    localparam int c_depth   = tree_depth(WIDTH);
    localparam int c_pad_w   = 1 << c_depth;
    localparam int c_stages  = num_stages(WIDTH, LEVELS_PER_STAGE);
    localparam int c_chain_w = bound_offset(WIDTH, LEVELS_PER_STAGE, c_stages);

    logic                 w_stall;
    logic                 w_last_in;
    logic [c_chain_w-1:0] w_chain;
    logic [c_stages-1:0]  w_vld;
    logic [c_stages-1:0]  w_lst;
    logic                 w_fin_valid;
    logic                 w_fin_last;
    logic                 w_fin_any;
    logic                 w_load;
    logic                 w_frame_any;
    logic                 r_out_valid;
    logic                 r_out_any;
    logic                 r_out_none;

    assign w_stall  = r_out_valid && !out_ready;
    assign in_ready = !w_stall;
    assign w_vld[0] = in_valid;
    assign w_lst[0] = w_last_in;

    if (c_pad_w > WIDTH) begin : g_pad
        assign w_chain[c_pad_w-1:0] = {{(c_pad_w-WIDTH){1'b0}}, in_data};
    end else begin : g_nopad
        assign w_chain[c_pad_w-1:0] = in_data;
    end

    // w_chain packs the partial-OR vector at every registered stage boundary.
    for (genvar k = 0; k < c_stages; k++) begin : g_stage
        localparam int c_in_w   = bound_width(WIDTH, LEVELS_PER_STAGE, k);
        localparam int c_in_off = bound_offset(WIDTH, LEVELS_PER_STAGE, k);
        localparam int c_lvls   = bound_level(WIDTH, LEVELS_PER_STAGE, k + 1)
                                - bound_level(WIDTH, LEVELS_PER_STAGE, k);

        if (k < c_stages - 1) begin : g_reg
            localparam int c_out_w   = bound_width(WIDTH, LEVELS_PER_STAGE, k + 1);
            localparam int c_out_off = bound_offset(WIDTH, LEVELS_PER_STAGE, k + 1);

            or_tree_stage #(
                .IN_W   (c_in_w),
                .LEVELS (c_lvls),
                .REG_EN (1)
            ) u_stage (
                .clock     (clock),
                .reset     (reset),
                .en        (!w_stall),
                .in_valid  (w_vld[k]),
                .in_last   (w_lst[k]),
                .in_data   (w_chain[c_in_off +: c_in_w]),
                .out_valid (w_vld[k+1]),
                .out_last  (w_lst[k+1]),
                .out_data  (w_chain[c_out_off +: c_out_w])
            );
        end else begin : g_last
            or_tree_stage #(
                .IN_W   (c_in_w),
                .LEVELS (c_lvls),
                .REG_EN (0)
            ) u_stage (
                .clock     (clock),
                .reset     (reset),
                .en        (!w_stall),
                .in_valid  (w_vld[k]),
                .in_last   (w_lst[k]),
                .in_data   (w_chain[c_in_off +: c_in_w]),
                .out_valid (w_fin_valid),
                .out_last  (w_fin_last),
                .out_data  (w_fin_any)
            );
        end
    end

    assign w_load = w_fin_valid && w_fin_last;

`ifdef OR_REDUCE_ACCUM_EN
    localparam logic [CNT_W-1:0] c_cnt_max = '1;

    logic             r_acc_any;
    logic [CNT_W-1:0] r_acc_cnt;
    logic [CNT_W-1:0] r_out_beats;
    logic [CNT_W-1:0] w_frame_cnt;

    assign w_last_in   = in_last;
    assign w_frame_any = r_acc_any | w_fin_any;
    assign w_frame_cnt = (r_acc_cnt == c_cnt_max) ? c_cnt_max : r_acc_cnt + 1'b1;

    // The closing beat clears the accumulator in the same cycle it publishes.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_acc_any   <= 1'b0;
            r_acc_cnt   <= '0;
            r_out_beats <= '0;
        end else if (!w_stall && w_fin_valid) begin
            if (w_fin_last) begin
                r_acc_any   <= 1'b0;
                r_acc_cnt   <= '0;
                r_out_beats <= w_frame_cnt;
            end else begin
                r_acc_any   <= w_frame_any;
                r_acc_cnt   <= w_frame_cnt;
            end
        end
    end

    assign out_beats = r_out_beats;
`else
    localparam logic [CNT_W-1:0] c_cnt_one = CNT_W'(1);

    logic w_unused_last;

    assign w_unused_last = in_last;
    assign w_last_in     = 1'b1;
    assign w_frame_any   = w_fin_any;
    assign out_beats     = c_cnt_one;
`endif

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_out_valid <= 1'b0;
            r_out_any   <= 1'b0;
            r_out_none  <= 1'b0;
        end else if (!w_stall) begin
            r_out_valid <= w_load;
            r_out_none  <= w_load && !w_frame_any;
            if (w_load) begin
                r_out_any <= w_frame_any;
            end
        end
    end

    assign out_valid = r_out_valid;
    assign out_any   = r_out_any;
    assign out_none  = r_out_none;

endmodule
`default_nettype wire

// File: tb/tb_or_reduce_pipe.sv
`default_nettype none
// ============================================================================
//  Module      : tb_or_reduce_pipe
//  Description : Directed self-checking bench for or_reduce_pipe (both the
//                default build and the OR_REDUCE_ACCUM_EN build).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_or_reduce_pipe;

    logic clock = 1'b0;
    logic reset;
    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    int n_checks = 0;
    int n_fail   = 0;

`ifdef OR_REDUCE_ACCUM_EN
    localparam logic [7:0] c_beats_rst = 8'd0;
`else
    localparam logic [7:0] c_beats_rst = 8'd1;
`endif

    // Main instance: WIDTH=32, LPS=2 -> three stages.
    logic        in_valid, in_ready, in_last, out_valid, out_ready, out_any, out_none;
    logic [31:0] in_data;
    logic [7:0]  out_beats;

    or_reduce_pipe #(.WIDTH(32), .LEVELS_PER_STAGE(2), .CNT_W(8)) u_dut (
        .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .in_last(in_last), .out_valid(out_valid),
        .out_ready(out_ready), .out_any(out_any), .out_none(out_none), .out_beats(out_beats)
    );

    logic        c_valid, c_ready, c_last, c_ovalid, c_oready, c_any, c_none;
    logic [31:0] c_data;
    logic [3:0]  c_beats;

    or_reduce_pipe #(.WIDTH(32), .LEVELS_PER_STAGE(2), .CNT_W(4)) u_cnt4 (
        .clock(clock), .reset(reset), .in_valid(c_valid), .in_ready(c_ready),
        .in_data(c_data), .in_last(c_last), .out_valid(c_ovalid),
        .out_ready(c_oready), .out_any(c_any), .out_none(c_none), .out_beats(c_beats)
    );

    logic        x_valid, x_last, x_oready;
    logic        x1_ready, x1_ovalid, x1_any, x1_none, x33_ready, x33_ovalid, x33_any, x33_none;
    logic [0:0]  x1_data;
    logic [32:0] x33_data;
    logic [7:0]  x1_beats, x33_beats;

    or_reduce_pipe #(.WIDTH(1), .LEVELS_PER_STAGE(2), .CNT_W(8)) u_w1 (
        .clock(clock), .reset(reset), .in_valid(x_valid), .in_ready(x1_ready),
        .in_data(x1_data), .in_last(x_last), .out_valid(x1_ovalid),
        .out_ready(x_oready), .out_any(x1_any), .out_none(x1_none), .out_beats(x1_beats)
    );

    or_reduce_pipe #(.WIDTH(33), .LEVELS_PER_STAGE(2), .CNT_W(8)) u_w33 (
        .clock(clock), .reset(reset), .in_valid(x_valid), .in_ready(x33_ready),
        .in_data(x33_data), .in_last(x_last), .out_valid(x33_ovalid),
        .out_ready(x_oready), .out_any(x33_any), .out_none(x33_none), .out_beats(x33_beats)
    );

    typedef struct {
        int         cyc;
        logic       any;
        logic       none;
        logic [7:0] beats;
    } rec_t;

    rec_t q[$];

    always @(negedge clock) begin
        if (!reset && out_valid && out_ready) q.push_back('{cyc, out_any, out_none, out_beats});
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    int acc_cyc;

    task automatic send(input logic [31:0] d, input logic l);
        int guard;
        guard    = 0;
        in_valid = 1'b1;
        in_data  = d;
        in_last  = l;
        @(negedge clock);
        while (!in_ready && guard < 50) begin
            @(negedge clock);
            guard++;
        end
        if (guard >= 50) chk("send_accept", in_ready, 1);
        @(posedge clock);
        #1;
        acc_cyc  = cyc;
        in_valid = 1'b0;
    endtask

    // Latency counts the accepting edge as cycle 1; -1 skips the latency check.
    task automatic expect_rec(input string tag, input logic any, input logic [7:0] beats, input int acc);
        rec_t r;
        if (q.size() == 0) begin
            chk({tag, "_present"}, q.size(), 1);
            return;
        end
        r = q.pop_front();
        chk({tag, "_any"}, r.any, any);
        chk({tag, "_none"}, r.none, !any);
        chk({tag, "_beats"}, r.beats, beats);
        if (acc >= 0) chk({tag, "_latency"}, r.cyc - acc + 1, 3);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at time %0t, expected $finish", $time);
        $fatal(1);
    end

    initial begin
        int a1, a2, a3, n, lat1, lat33;
        logic held, any1, any33, exp1;

        reset = 1'b1;
        {in_valid, in_last, c_valid, c_last, x_valid, x_last} = '0;
        in_data = '0; c_data = '0; x1_data = '0; x33_data = '0;
        out_ready = 1'b1; c_oready = 1'b1; x_oready = 1'b1;
        a1 = 0; a2 = 0; a3 = 0;

        tick(2);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_any", out_any, 0);
        chk("rst_out_none", out_none, 0);
        chk("rst_out_beats", out_beats, c_beats_rst);
        chk("rst_in_ready", in_ready, 1);
        @(negedge clock);
        reset = 1'b0;
        tick(1);

`ifdef OR_REDUCE_ACCUM_EN
        send(32'h0, 1'b0);
        send(32'h0001_0000, 1'b0);
        send(32'h0, 1'b1);
        a3 = acc_cyc;
        tick(5);
        chk("frame1_count", q.size(), 1);
        expect_rec("frame1", 1'b1, 8'd3, a3);
        send(32'h0, 1'b1);
        a1 = acc_cyc;
        tick(5);
        chk("frame2_count", q.size(), 1);
        expect_rec("frame2", 1'b0, 8'd1, a1);
`else
        send(32'h0, 1'b0);
        a1 = acc_cyc;
        send(32'h8000_0000, 1'b0);
        a2 = acc_cyc;
        tick(5);
        chk("b2b_count", q.size(), 2);
        expect_rec("b2b0", 1'b0, 8'd1, a1);
        expect_rec("b2b1", 1'b1, 8'd1, a2);
`endif

        // Back-pressure: eight single-beat frames, consumer stalls for 4 cycles.
        fork
            begin
                for (int i = 0; i < 8; i++) send((i % 2) ? (32'h1 << (i * 3)) : 32'h0, 1'b1);
            end
            begin
                tick(4);
                out_ready = 1'b0;
                held      = out_any;
                for (int j = 0; j < 4; j++) begin
                    @(negedge clock);
                    chk("stall_in_ready", in_ready, 0);
                    chk("stall_valid", out_valid, 1);
                    chk("stall_hold_any", out_any, held);
                end
                @(posedge clock);
                #1;
                out_ready = 1'b1;
            end
        join
        tick(6);
        chk("stall_count", q.size(), 8);
        for (int i = 0; i < 8; i++) expect_rec($sformatf("stall%0d", i), i % 2, 8'd1, -1);

        // Asynchronous reset with a held result and a partial frame in flight.
        q.delete();
        out_ready = 1'b0;
        send(32'hFFFF_FFFF, 1'b1);
        send(32'hFFFF_FFFF, 1'b0);
        send(32'hFFFF_FFFF, 1'b0);
        tick(3);
        chk("pre_rst_valid", out_valid, 1);
        chk("pre_rst_any", out_any, 1);
        chk("pre_rst_in_ready", in_ready, 0);
        #2;
        reset = 1'b1;
        #1;
        chk("mid_rst_valid", out_valid, 0);
        chk("mid_rst_any", out_any, 0);
        chk("mid_rst_none", out_none, 0);
        chk("mid_rst_beats", out_beats, c_beats_rst);
        chk("mid_rst_in_ready", in_ready, 1);
        tick(1);
        @(negedge clock);
        reset     = 1'b0;
        out_ready = 1'b1;
        tick(1);
        chk("post_rst_in_ready", in_ready, 1);
        send(32'h0, 1'b1);
        a1 = acc_cyc;
        tick(5);
        chk("post_rst_count", q.size(), 1);
        expect_rec("post_rst", 1'b0, 8'd1, a1);

`ifdef OR_REDUCE_ACCUM_EN
        c_valid = 1'b1;
        c_data  = 32'h0;
        for (int i = 0; i < 20; i++) begin
            c_last = (i == 19);
            tick(1);
        end
        chk("sat_in_ready", c_ready, 1);
        c_valid = 1'b0;
        c_last  = 1'b0;
`else
        c_valid = 1'b1;
        c_data  = 32'h4;
        c_last  = 1'b0;
        tick(1);
        chk("cnt4_in_ready", c_ready, 1);
        c_valid = 1'b0;
`endif
        n = 0;
        while (!c_ovalid && n < 10) begin
            tick(1);
            n++;
        end
        chk("cnt4_valid", c_ovalid, 1);
`ifdef OR_REDUCE_ACCUM_EN
        chk("sat_beats", c_beats, 4'd15);
        chk("sat_none", c_none, 1);
        chk("sat_any", c_any, 0);
`else
        chk("cnt4_beats", c_beats, 4'd1);
        chk("cnt4_any", c_any, 1);
        chk("cnt4_none", c_none, 0);
`endif

        // WIDTH=1 (latency 1) and WIDTH=33 (padded, latency 3), two patterns.
        for (int p = 0; p < 2; p++) begin
            exp1     = (p == 0);
            x_valid  = 1'b1;
            x_last   = 1'b1;
            x1_data  = exp1;
            x33_data = (p == 0) ? 33'h0_0000_0001 : 33'h1_0000_0000;
            chk($sformatf("w1_in_ready%0d", p), x1_ready, 1);
            chk($sformatf("w33_in_ready%0d", p), x33_ready, 1);
            tick(1);
            x_valid = 1'b0;
            lat1 = 0; lat33 = 0; any1 = 1'b0; any33 = 1'b0;
            for (int k = 1; k <= 6; k++) begin
                if (x1_ovalid && lat1 == 0) begin
                    lat1 = k;
                    any1 = x1_any;
                    chk($sformatf("w1_none%0d", p), x1_none, !exp1);
                    chk($sformatf("w1_beats%0d", p), x1_beats, 1);
                end
                if (x33_ovalid && lat33 == 0) begin
                    lat33 = k;
                    any33 = x33_any;
                    chk($sformatf("w33_none%0d", p), x33_none, 0);
                    chk($sformatf("w33_beats%0d", p), x33_beats, 1);
                end
                tick(1);
            end
            chk($sformatf("w1_latency%0d", p), lat1, 1);
            chk($sformatf("w33_latency%0d", p), lat33, 3);
            chk($sformatf("w1_any%0d", p), any1, exp1);
            chk($sformatf("w33_any%0d", p), any33, 1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/or_reduce_pipe.md
# or_reduce_pipe

Parametrised, pipelined OR-reduction unit that generalises the fixed 8-input OR tree to any `WIDTH`. Register stages are inserted every `LEVELS_PER_STAGE` tree levels, and a valid/ready handshake is provided. An optional frame accumulator ORs multiple beats together and counts them. It serves the ALU and datapath for wide zero/nonzero detection, such as result-is-zero and multi-word compare flags.

## Interface
- `WIDTH`, 32, input word width (≥1)
- `LEVELS_PER_STAGE`, 2, OR-tree levels between pipeline registers (≥1)
- `CNT_W`, 8, width of beat counter
- `clock`  input  1  rising-edge clock
- `reset`  input  1  asynchronous, active-high reset
- `in_valid`  input  1  beat offered
- `in_ready`  output  1  beat accepted when `in_valid && in_ready`
- `in_data`  input  `WIDTH`  word to reduce
- `in_last`  input  1  last beat of frame (used only with accumulator)
- `out_valid`  output  1  result available
- `out_ready`  input  1  consumer accepts result
- `out_any`  output  1  OR of all bits of all beats of frame
- `out_none`  output  1  `~out_any`, qualified by `out_valid`
- `out_beats`  output  `CNT_W`  beats in frame, saturating

## Operation
- Tree: D = ceil(log2(WIDTH)) levels of 2-input OR. Pad to the next power of two with zeros. D=0 for WIDTH=1.
- Stages: S = max(1, ceil(D / LEVELS_PER_STAGE)). Each stage holds partial ORs plus valid, last, and per-beat data.
- Global stall: `stall = out_valid && !out_ready`. On stall, all stage registers hold. `in_ready = !stall`. Bubbles are not compressed.
- Final stage merges the tree result with the accumulator: `acc_any | tree_result` and `acc_cnt + 1` (saturating at 2^CNT_W−1).
- A beat reaching the final stage with last=0 updates `acc_any`/`acc_cnt` and produces no output.
- A beat with last=1 loads `out_*`, sets `out_valid`, and clears `acc_any`/`acc_cnt` in the same cycle. A following frame therefore starts clean with no dead cycle.
- `out_valid` clears on `out_ready` unless a new result loads in the same cycle.
- Reset (any time, including mid-frame): all stage valids=0, `acc_any`=0, `acc_cnt`=0, `out_valid`=0, `out_any`=0, `out_none`=0, `out_beats`=0. `in_ready`=1 while reset is deasserted and no output is pending.

## Timing
- Latency: S cycles from acceptance of the last beat to `out_valid`. Defaults: D=5, S=3.
- Throughput: one beat per cycle when `out_ready`=1.
- Outputs are registered. `in_ready` is combinational from `out_valid`/`out_ready` only.
- Outputs are stable while `out_valid && !out_ready`.

## Configuration
- `OR_REDUCE_ACCUM_EN` defined: frame accumulator and beat counter as described above.
- Not defined: `in_last` is ignored and every beat is treated as last. Each accepted beat yields one result after S cycles. `out_beats` is driven to constant 1. Accumulator registers are not generated.

## Structure
- `or_reduce_pkg`: `clog2` function, functions for D and S, default `WIDTH`/`LEVELS_PER_STAGE`/`CNT_W`.
- Sub-module `or_tree_stage`: `LEVELS_PER_STAGE` combinational OR levels plus enable-gated register with valid/last. Instantiated S times via generate.
- Top level: padding, stage chain, accumulator/counter, stall logic.

## Test plan
Defaults WIDTH=32, LPS=2 (S=3) unless noted.
1. Reset asserted mid-stream → all outputs 0 in the same cycle (async); `in_ready`=1 after deassertion.
2. Accumulator off: beats 0x00000000 and 0x80000000 back-to-back → results 3 cycles after each, in order: (any=0, none=1, beats=1), then (any=1, none=0, beats=1).
3. Accumulator on: frame of 0x0, 0x00010000, 0x0 (last on beat 3) → exactly one `out_valid`, 3 cycles after beat 3, any=1, beats=3. Next frame 0x0 (single beat, last) → any=0, beats=1.
4. Continuous input with `out_ready`=0 for 4 cycles → `in_ready`=0 during stall, outputs held; no results lost or reordered after release.
5. CNT_W=4: 20-beat all-zero frame → beats=15 (saturated), none=1. WIDTH=1 and WIDTH=33 single beats 0x1 → any=1, latency 1 and 3 respectively.
6. Frame of two beats 0xFFFFFFFF, reset, then one-beat frame 0x0 → any=0, beats=1.
